// File: rtl/sm3_dma_master_if.sv
// AHB-Lite master bus bundle for sm3_dma_master.
// The master modport drives the address/control/write-data side; the slave
// modport is the view of a memory or interconnect answering those transfers.
interface sm3_dma_master_if;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;
    logic        M_HRESP;

    modport master (
        output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA,
        input  M_HRDATA, M_HREADY, M_HRESP
    );

    modport slave (
        input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA,
        output M_HRDATA, M_HREADY, M_HRESP
    );
endinterface

// File: rtl/sm3_dma_master.sv
// sm3_dma_master: AHB-Lite master that reads BSR words from SAR_ADDR into the
// SM3 core, then writes OUT_WORDS digest words back to DAR_ADDR, and pulses
// SET_STR when finished. One transfer at a time, IDLE between transfers.
// Optional build macro SM3_DMA_BYTESWAP_EN: byte-reverse words in both
// directions (little-endian memory <-> big-endian SM3 word order).
module sm3_dma_master #(
    parameter int OUT_WORDS = 8
) (
    input  logic             AHB_HCLK,
    input  logic             AHB_HRESETN,
    input  logic             ENABLE,
    input  logic [12:0]      SAR_ADDR,
    input  logic [12:0]      DAR_ADDR,
    input  logic [12:0]      BSR,
    output logic             SET_STR,
    sm3_dma_master_if.master ahb,
    output logic [31:0]      DIN,
    output logic             DIN_VALID,
    input  logic             DIN_READY,
    input  logic [31:0]      DOUT,
    input  logic             DOUT_VALID,
    output logic             DOUT_READY,
    output logic             BUS_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_PUSH, S_WOUT, S_WADDR, S_WDATA, S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(OUT_WORDS - 1);
    localparam logic [1:0] HT_IDLE  = 2'b00;
    localparam logic [1:0] HT_NSEQ  = 2'b10;

    state_t      r_state, w_next;
    logic        r_en_d;
    logic [10:0] r_sword, r_dword;
    logic [12:0] r_remain;
    logic [3:0]  r_wcnt;
    logic [10:0] r_haddr, w_haddr;
    logic [1:0]  r_htrans, w_htrans;
    logic        r_hwrite, w_hwrite;
    logic [31:0] r_hwdata, r_din;
    logic        r_din_vld, w_din_vld;
    logic        r_dout_rdy, w_dout_rdy;
    logic        r_set_str, w_set_str;
    logic        r_bus_err;
    logic        w_start, w_rd_ok, w_wr_ok, w_err;
    logic        w_unused;

    // Word order between memory and the hash core.
    function automatic logic [31:0] f_byte_order(input logic [31:0] d);
`ifdef SM3_DMA_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Byte-offset bits of the programmed addresses are not used.
    assign w_unused = ^{SAR_ADDR[1:0], DAR_ADDR[1:0]};

    assign w_start = (r_state == S_IDLE) && ENABLE && !r_en_d;
    assign w_rd_ok = (r_state == S_RDATA) && ahb.M_HREADY && !ahb.M_HRESP && ENABLE;
    assign w_wr_ok = (r_state == S_WDATA) && ahb.M_HREADY && !ahb.M_HRESP && ENABLE;
    assign w_err   = ((r_state == S_RDATA) || (r_state == S_WDATA)) && ahb.M_HRESP;

    // State register.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    // Next-state decode; an accepted address phase always runs its data phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = (BSR != 13'd0) ? S_RADDR : S_WOUT;
            S_RADDR: if (ahb.M_HREADY) w_next = S_RDATA;
            S_RDATA: begin
                if (ahb.M_HRESP)       w_next = ENABLE ? S_DONE : S_IDLE;
                else if (ahb.M_HREADY) w_next = ENABLE ? S_PUSH : S_IDLE;
            end
            S_PUSH: begin
                if (!ENABLE)        w_next = S_IDLE;
                else if (DIN_READY) w_next = (r_remain != 13'd0) ? S_RADDR : S_WOUT;
            end
            S_WOUT: begin
                if (!ENABLE)         w_next = S_IDLE;
                else if (DOUT_VALID) w_next = S_WADDR;
            end
            S_WADDR: if (ahb.M_HREADY) w_next = S_WDATA;
            S_WDATA: begin
                if (ahb.M_HRESP)       w_next = ENABLE ? S_DONE : S_IDLE;
                else if (ahb.M_HREADY) begin
                    if (!ENABLE)                 w_next = S_IDLE;
                    else if (r_wcnt == LAST_IDX) w_next = S_DONE;
                    else                         w_next = S_WOUT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state, so every output leaves a flop.
    always_comb begin
        w_htrans   = ((w_next == S_RADDR) || (w_next == S_WADDR)) ? HT_NSEQ : HT_IDLE;
        w_hwrite   = (w_next == S_WADDR);
        w_din_vld  = (w_next == S_PUSH);
        w_dout_rdy = (w_next == S_WOUT);
        w_set_str  = (w_next == S_DONE);
        w_haddr    = r_haddr;
        if (w_next == S_RADDR)
            w_haddr = (r_state == S_IDLE) ? SAR_ADDR[12:2] : r_sword;
        else if (w_next == S_WADDR)
            w_haddr = r_dword;
    end

    // Registered bus and handshake outputs.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) begin
            r_haddr    <= '0;
            r_htrans   <= HT_IDLE;
            r_hwrite   <= 1'b0;
            r_din_vld  <= 1'b0;
            r_dout_rdy <= 1'b0;
            r_set_str  <= 1'b0;
        end else begin
            r_haddr    <= w_haddr;
            r_htrans   <= w_htrans;
            r_hwrite   <= w_hwrite;
            r_din_vld  <= w_din_vld;
            r_dout_rdy <= w_dout_rdy;
            r_set_str  <= w_set_str;
        end
    end

    // Counters, data registers and the sticky error flag.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) begin
            r_en_d    <= 1'b0;
            r_sword   <= '0;
            r_dword   <= '0;
            r_remain  <= '0;
            r_wcnt    <= '0;
            r_din     <= '0;
            r_hwdata  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_en_d <= ENABLE;
            if (w_start) begin
                r_sword   <= SAR_ADDR[12:2];
                r_dword   <= DAR_ADDR[12:2];
                r_remain  <= BSR;
                r_wcnt    <= '0;
                r_bus_err <= 1'b0;
            end
            if (w_rd_ok) begin
                r_din    <= f_byte_order(ahb.M_HRDATA);
                r_sword  <= r_sword + 11'd1;
                r_remain <= r_remain - 13'd1;
            end
            if ((r_state == S_WOUT) && ENABLE && DOUT_VALID)
                r_hwdata <= f_byte_order(DOUT);
            if (w_wr_ok) begin
                r_dword <= r_dword + 11'd1;
                r_wcnt  <= r_wcnt + 4'd1;
            end
            if (w_err)
                r_bus_err <= 1'b1;
        end
    end

    // Core handshakes are masked by ENABLE so an abort never completes one.
    assign DIN_VALID    = r_din_vld & ENABLE;
    assign DOUT_READY   = r_dout_rdy & ENABLE;
    assign DIN          = r_din;
    assign SET_STR      = r_set_str;
    assign BUS_ERR      = r_bus_err;
    assign ahb.M_HADDR  = {19'b0, r_haddr, 2'b00};
    assign ahb.M_HTRANS = r_htrans;
    assign ahb.M_HWRITE = r_hwrite;
    assign ahb.M_HSIZE  = 3'b010;
    assign ahb.M_HWDATA = r_hwdata;

endmodule

// File: tb/tb_sm3_dma_master.sv
// Bench for sm3_dma_master: AHB memory model with wait-state/error injection,
// SM3 core model, and a scoreboard of expected bus transfers and DIN words.
module tb_sm3_dma_master;
    localparam int OUT_W = 8;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        ENABLE;
    logic [12:0] SAR_ADDR, DAR_ADDR, BSR;
    logic        SET_STR;
    logic [31:0] DIN;
    logic        DIN_VALID, DIN_READY;
    logic [31:0] DOUT;
    logic        DOUT_VALID, DOUT_READY;
    logic        BUS_ERR;

    sm3_dma_master_if bus ();

    sm3_dma_master #(.OUT_WORDS(OUT_W)) dut (
        .AHB_HCLK    (clk),
        .AHB_HRESETN (rst_n),
        .ENABLE      (ENABLE),
        .SAR_ADDR    (SAR_ADDR),
        .DAR_ADDR    (DAR_ADDR),
        .BSR         (BSR),
        .SET_STR     (SET_STR),
        .ahb         (bus),
        .DIN         (DIN),
        .DIN_VALID   (DIN_VALID),
        .DIN_READY   (DIN_READY),
        .DOUT        (DOUT),
        .DOUT_VALID  (DOUT_VALID),
        .DOUT_READY  (DOUT_READY),
        .BUS_ERR     (BUS_ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int set_cnt  = 0;
    int set_cyc  = 0;
    int last_wr_cyc = 0;
    int din_hs   = 0;
    int dout_idx = 0;
    int cfg_wait = 0;

    xfer_t       xq[$];
    logic [31:0] dq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1122_3344;
        return 32'h5A00_0000 ^ (a * 32'h0001_0003);
    endfunction

    function automatic logic [31:0] dig(input int i);
        return 32'h6A09_E667 ^ (32'(i) * 32'h0100_0193);
    endfunction

    function automatic logic [31:0] to_core(input logic [31:0] d);
`ifdef SM3_DMA_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // AHB memory slave + SM3 core model + scoreboard checks, all at negedge.
    logic        dp_act = 1'b0;
    logic        dp_wr  = 1'b0;
    logic [31:0] dp_addr = '0;
    int          dp_wait = 0;
    logic        dout_adv = 1'b0;
    xfer_t       mon_e;
    logic [31:0] mon_d;

    initial begin
        bus.M_HREADY = 1'b1;
        bus.M_HRESP  = 1'b0;
        bus.M_HRDATA = '0;
        DOUT         = dig(0);
        forever begin
            @(negedge clk);
            if (dout_adv) begin
                dout_idx++;
                DOUT     = dig(dout_idx);
                dout_adv = 1'b0;
            end
            if (dp_act) begin
                if (dp_wait > 0) begin
                    bus.M_HREADY = 1'b0;
                    bus.M_HRESP  = 1'b0;
                    dp_wait--;
                end else begin
                    bus.M_HREADY = 1'b1;
                    bus.M_HRESP  = 1'b0;
                    chk_eq("xfer_expected", 32'(xq.size() != 0), 32'd1);
                    if (xq.size() != 0) begin
                        mon_e = xq.pop_front();
                        chk_eq("xfer_hwrite", 32'(dp_wr), 32'(mon_e.wr));
                        chk_eq("xfer_haddr", dp_addr, mon_e.addr);
                        bus.M_HRESP = mon_e.err;
                        if (dp_wr) begin
                            chk_eq("hwdata", bus.M_HWDATA, mon_e.data);
                            last_wr_cyc = cyc;
                        end else begin
                            bus.M_HRDATA = mon_e.err ? 32'hDEAD_DEAD : mem_at(dp_addr);
                        end
                    end
                    dp_act = 1'b0;
                end
            end else begin
                bus.M_HREADY = 1'b1;
                bus.M_HRESP  = 1'b0;
            end
            if (bus.M_HTRANS == 2'b10 && bus.M_HREADY) begin
                chk_eq("hsize", 32'(bus.M_HSIZE), 32'd2);
                dp_act  = 1'b1;
                dp_addr = bus.M_HADDR;
                dp_wr   = bus.M_HWRITE;
                dp_wait = cfg_wait;
            end
            if (DIN_VALID && DIN_READY) begin
                din_hs++;
                chk_eq("din_expected", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    mon_d = dq.pop_front();
                    chk_eq("din", DIN, mon_d);
                end
            end
            if (DOUT_VALID && DOUT_READY) dout_adv = 1'b1;
            if (SET_STR) begin
                set_cnt++;
                set_cyc = cyc;
            end
        end
    end

    // One full operation: push expectations, start, wait for SET_STR, check.
    task automatic run_op(input logic [12:0] sar, input logic [12:0] dar, input int bsr,
                          input int waits, input int err_at, input int exp_lat);
        xfer_t       e;
        logic [12:0] a;
        logic        erred;
        int          s0, t0;
        erred = 1'b0;
        for (int i = 0; i < bsr && !erred; i++) begin
            a      = (sar & 13'h1FFC) + 13'(4 * i);
            e.wr   = 1'b0;
            e.err  = (i == err_at);
            e.addr = {19'b0, a};
            e.data = '0;
            xq.push_back(e);
            if (i == err_at) erred = 1'b1;
            else             dq.push_back(to_core(mem_at(e.addr)));
        end
        if (!erred) begin
            for (int k = 0; k < OUT_W; k++) begin
                a      = (dar & 13'h1FFC) + 13'(4 * k);
                e.wr   = 1'b1;
                e.err  = 1'b0;
                e.addr = {19'b0, a};
                e.data = to_core(dig(dout_idx + k));
                xq.push_back(e);
            end
        end
        cfg_wait = waits;
        SAR_ADDR = sar;
        DAR_ADDR = dar;
        BSR      = 13'(bsr);
        tick();
        s0 = set_cnt;
        ENABLE = 1'b1;
        tick();
        t0 = cyc;
        chk_eq("start_htrans", 32'(bus.M_HTRANS), (bsr != 0) ? 32'd2 : 32'd0);
        chk_eq("start_bus_err_cleared", 32'(BUS_ERR), 32'd0);
        if (bsr != 0) chk_eq("start_haddr", bus.M_HADDR, {19'b0, sar & 13'h1FFC});
        for (int t = 0; t < 3000 && set_cnt == s0; t++) tick();
        repeat (4) tick();
        chk_eq("set_str_pulses", 32'(set_cnt - s0), 32'd1);
        chk_eq("bus_err", 32'(BUS_ERR), 32'(erred));
        chk_eq("xfers_left", 32'(xq.size()), 32'd0);
        chk_eq("din_left", 32'(dq.size()), 32'd0);
        if (exp_lat >= 0) begin
            chk_eq("done_latency", 32'(set_cyc - t0), 32'(exp_lat));
            chk_eq("set_str_after_last_write", 32'(set_cyc - last_wr_cyc), 32'd1);
        end
        ENABLE = 1'b0;
        tick();
    endtask

    initial begin
        xfer_t e;
        int    s0, h0;
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t e;
        int    s0, h0;
        rst_n      = 1'b0;
        ENABLE     = 1'b0;
        SAR_ADDR   = '0;
        DAR_ADDR   = '0;
        BSR        = '0;
        DIN_READY  = 1'b1;
        DOUT_VALID = 1'b1;
        repeat (3) tick();
        chk_eq("rst_htrans", 32'(bus.M_HTRANS), 32'd0);
        chk_eq("rst_haddr", bus.M_HADDR, 32'd0);
        chk_eq("rst_hwrite", 32'(bus.M_HWRITE), 32'd0);
        chk_eq("rst_hwdata", bus.M_HWDATA, 32'd0);
        chk_eq("rst_hsize", 32'(bus.M_HSIZE), 32'd2);
        chk_eq("rst_set_str", 32'(SET_STR), 32'd0);
        chk_eq("rst_din", DIN, 32'd0);
        chk_eq("rst_din_valid", 32'(DIN_VALID), 32'd0);
        chk_eq("rst_dout_ready", 32'(DOUT_READY), 32'd0);
        chk_eq("rst_bus_err", 32'(BUS_ERR), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic read 3 / write 8, zero wait; first word carries 0x11223344.
        run_op(13'h0100, 13'h0200, 3, 0, -1, 3 * 3 + 3 * OUT_W);
        // No source words: straight to digest write-back.
        run_op(13'h0000, 13'h0240, 0, 0, -1, 3 * OUT_W);
        // Source address wraps at the top of the 8 KB window, two wait states.
        run_op(13'h1FF8, 13'h0300, 4, 2, -1, -1);
        // Error response on the second read.
        run_op(13'h0040, 13'h0400, 4, 0, 1, -1);
        // Next start clears the sticky error.
        run_op(13'h0080, 13'h0600, 1, 0, -1, 3 + 3 * OUT_W);

        // Abort during PUSH of the second word.
        for (int i = 0; i < 2; i++) begin
            e.wr   = 1'b0;
            e.err  = 1'b0;
            e.addr = 32'h0000_0400 + 32'(4 * i);
            e.data = '0;
            xq.push_back(e);
        end
        dq.push_back(to_core(mem_at(32'h0000_0400)));
        cfg_wait = 0;
        SAR_ADDR = 13'h0400;
        DAR_ADDR = 13'h0700;
        BSR      = 13'd4;
        tick();
        s0 = set_cnt;
        h0 = din_hs;
        ENABLE = 1'b1;
        for (int t = 0; t < 200 && din_hs == h0; t++) tick();
        DIN_READY = 1'b0;
        for (int t = 0; t < 200 && !DIN_VALID; t++) tick();
        chk_eq("abort_in_push", 32'(DIN_VALID), 32'd1);
        ENABLE = 1'b0;
        tick();
        chk_eq("abort_htrans", 32'(bus.M_HTRANS), 32'd0);
        chk_eq("abort_din_valid", 32'(DIN_VALID), 32'd0);
        repeat (10) tick();
        chk_eq("abort_no_set_str", 32'(set_cnt - s0), 32'd0);
        chk_eq("abort_din_count", 32'(din_hs - h0), 32'd1);
        chk_eq("abort_xfers_left", 32'(xq.size()), 32'd0);
        chk_eq("abort_din_left", 32'(dq.size()), 32'd0);
        DIN_READY = 1'b1;
        tick();

        // Restart after abort, with one wait state.
        run_op(13'h0010, 13'h0700, 2, 1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
